// File: rtl/rle_decoder.sv
// Run-length token expander: turns (run, value) and end-of-block tokens into a stream
// of BLK_N-coefficient blocks, one coefficient per beat, behind a single output register.
module rle_decoder #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned RUN_W  = 3,
  parameter int unsigned BLK_N  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DATA_W-1:0]        in_value,
  input  logic        [RUN_W-1:0]         in_run,
  input  logic                            in_eob,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [DATA_W-1:0]        out_data,
  output logic        [$clog2(BLK_N)-1:0] out_idx,
  output logic                            out_last,
  output logic                            err
);
  localparam int unsigned IdxW = $clog2(BLK_N);
  localparam int unsigned CntW = IdxW + 1;

  // StRun: zeros still to be loaded; StVal: only the token value still to be loaded.
  typedef enum logic [1:0] {StIdle, StRun, StVal} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          left_q, left_d;
  logic                     val_pend_q, val_pend_d;
  logic signed [DATA_W-1:0] val_q, val_d;
  logic [IdxW-1:0]          pos_q, pos_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [IdxW-1:0]          out_idx_q, out_idx_d;
  logic                     out_last_q, out_last_d;
  logic                     err_q, err_d;

  logic                     can_load, accept, ovf, tok_val, load;
  logic [CntW-1:0]          sum, fill, tok_zeros;
  logic signed [DATA_W-1:0] load_data;

  assign can_load  = !out_valid_q || out_ready;
  assign in_ready  = can_load && (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, pos_q} + CntW'(in_run);
  assign fill      = CntW'(BLK_N) - {1'b0, pos_q};
  assign ovf       = !in_eob && (sum > CntW'(BLK_N - 1));
  assign tok_val   = !in_eob && !ovf;
  assign tok_zeros = (in_eob || ovf) ? fill : CntW'(in_run);

  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    val_pend_d  = val_pend_q;
    val_d       = val_q;
    pos_d       = pos_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    load        = 1'b0;
    load_data   = '0;

    if (accept) begin
      // The first beat of an accepted token goes straight into the output register.
      load  = 1'b1;
      err_d = err_q | ovf;
      val_d = in_value;
      if (tok_zeros != '0) begin
        left_d     = tok_zeros - CntW'(1);
        val_pend_d = tok_val;
        if (tok_zeros != CntW'(1)) begin
          state_d = StRun;
        end else if (tok_val) begin
          state_d = StVal;
        end else begin
          state_d = StIdle;
        end
      end else begin
        load_data  = in_value;
        left_d     = '0;
        val_pend_d = 1'b0;
        state_d    = StIdle;
      end
    end else if (can_load) begin
      unique case (state_q)
        StRun: begin
          load   = 1'b1;
          left_d = left_q - CntW'(1);
          if (left_q == CntW'(1)) begin
            state_d = val_pend_q ? StVal : StIdle;
          end
        end
        StVal: begin
          load       = 1'b1;
          load_data  = val_q;
          val_pend_d = 1'b0;
          state_d    = StIdle;
        end
        default: ;
      endcase
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
      out_idx_d   = pos_q;
      out_last_d  = (pos_q == IdxW'(BLK_N - 1));
      pos_d       = pos_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      left_q      <= '0;
      val_pend_q  <= 1'b0;
      val_q       <= '0;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      val_pend_q  <= val_pend_d;
      val_q       <= val_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rle_decoder.sv
// Bench for rle_decoder: directed block scenarios plus random token streams, checked
// beat-by-beat against a token-expansion model held in a queue.
module tb_rle_decoder;
  localparam int BLK = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_value;
  logic [2:0]  in_run;
  logic        in_eob;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        err;

  rle_decoder #(.DATA_W(18), .RUN_W(3), .BLK_N(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .in_run   (in_run),
    .in_eob   (in_eob),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] data;
    int          idx;
  } exp_t;

  typedef struct {
    logic [17:0] data;
    int          idx;
    logic        last;
    int          cyc;
  } got_t;

  exp_t exp_q[$];
  got_t got_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_pos   = 0;
  logic m_err   = 1'b0;
  int   or_mode = 0;
  int   cyc_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [17:0] d);
    exp_t e;
    e.data = d;
    e.idx  = m_pos;
    exp_q.push_back(e);
    m_pos = (m_pos + 1) % BLK;
  endtask

  // Expansion straight from the token rules: zeros first, then the value if it fits.
  task automatic model_accept(input logic eob, input int run, input logic [17:0] v);
    int   zeros;
    logic has_val;
    has_val = 1'b0;
    if (eob) begin
      zeros = BLK - m_pos;
    end else if (m_pos + run > BLK - 1) begin
      zeros = BLK - m_pos;
      m_err = 1'b1;
    end else begin
      zeros   = run;
      has_val = 1'b1;
    end
    for (int i = 0; i < zeros; i++) push_exp(18'd0);
    if (has_val) push_exp(v);
  endtask

  // Monitor: samples 2 time units before each rising edge.
  logic        prev_stall = 1'b0;
  logic [17:0] ps_data;
  logic [2:0]  ps_idx;
  logic        lat_pend = 1'b0;

  always begin
    @(posedge clk);
    #8;
    cyc_n++;
    if (reset) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_idx", 32'(out_idx), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      m_pos      = 0;
      m_err      = 1'b0;
      prev_stall = 1'b0;
      lat_pend   = 1'b0;
    end else begin
      check("err_flag", 32'(err), 32'(m_err));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(ps_data));
        check("hold_idx", 32'(out_idx), 32'(ps_idx));
      end
      if (lat_pend) begin
        check("latency_valid", 32'(out_valid), 32'd1);
        if (exp_q.size() != 0) check("latency_data", 32'(out_data), 32'(exp_q[0].data));
      end
      lat_pend = 1'b0;
      if (out_valid && out_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          got_t g;
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e.data));
          check("beat_idx", 32'(out_idx), 32'(e.idx));
          check("beat_last", 32'(out_last), 32'(e.idx == BLK - 1));
          g.data = out_data;
          g.idx  = int'(out_idx);
          g.last = out_last;
          g.cyc  = cyc_n;
          got_q.push_back(g);
        end
      end
      prev_stall = out_valid && !out_ready;
      ps_data    = out_data;
      ps_idx     = out_idx;
      if (in_valid && in_ready) begin
        model_accept(in_eob, int'(in_run), in_value);
        lat_pend = 1'b1;
      end
    end
  end

  int or_cyc = 0;
  always begin
    @(posedge clk);
    #2;
    or_cyc++;
    case (or_mode)
      1:       out_ready = (or_cyc % 3 == 0);
      2:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Entered and left 2 units after a rising edge; stalls = cycles in_ready was low.
  task automatic send(input logic eob, input int run, input logic [17:0] val,
                      output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_eob   = eob;
    in_run   = 3'(run);
    in_value = val;
    #6;
    while (!in_ready) begin
      stalls++;
      if (stalls > 200) begin
        check("send_ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
      @(posedge clk);
      #8;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 500) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_seq(input string name, input int n, input logic [17:0] d[8],
                           input int idx0);
    check({name, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check({name, "_data"}, 32'(got_q[i].data), 32'(d[i]));
      check({name, "_idx"}, 32'(got_q[i].idx), 32'((idx0 + i) % BLK));
      check({name, "_last"}, 32'(got_q[i].last), 32'(((idx0 + i) % BLK) == BLK - 1));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] d8[8];
    int          st;
    int          tot;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_eob    = 1'b0;
    in_run    = '0;
    in_value  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;

    // Eight R=0 tokens stream without bubbles.
    got_q.delete();
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 0, 18'd5, st);
      tot += st;
    end
    drain();
    d8 = '{default: 18'd5};
    check_seq("r0_stream", 8, d8, 0);
    check("r0_ready_stalls", 32'(tot), 32'd0);
    if (got_q.size() == 8) check("r0_no_bubble", 32'(got_q[7].cyc - got_q[0].cyc), 32'd7);

    // R=2, V=-3 then EOB; EOB waits R cycles for in_ready.
    got_q.delete();
    send(1'b0, 2, 18'h3FFFD, st);
    send(1'b1, 0, 18'd0, st);
    check("run2_ready_low", 32'(st), 32'd2);
    drain();
    d8 = '{18'd0, 18'd0, 18'h3FFFD, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
    check_seq("run2_eob", 8, d8, 0);

    // EOB at pos 0 fills a whole block.
    got_q.delete();
    send(1'b1, 0, 18'd0, st);
    drain();
    d8 = '{default: 18'd0};
    check_seq("eob_pos0", 8, d8, 0);
    check("eob_pos0_err", 32'(err), 32'd0);

    // Backpressure pattern 1,0,0,...
    got_q.delete();
    or_mode = 1;
    send(1'b0, 3, 18'h1FFFF, st);
    drain();
    or_mode = 0;
    d8 = '{18'd0, 18'd0, 18'd0, 18'h1FFFF, 18'd0, 18'd0, 18'd0, 18'd0};
    check_seq("stall", 4, d8, 0);

    // Overflow from pos 6.
    send(1'b1, 0, 18'd0, st);
    for (int i = 0; i < 6; i++) send(1'b0, 0, 18'(i + 1), st);
    drain();
    check("ovf_err_before", 32'(err), 32'd0);
    got_q.delete();
    send(1'b0, 3, 18'd9, st);
    check("ovf_err_next", 32'(err), 32'd1);
    send(1'b0, 0, 18'd1, st);
    drain();
    d8 = '{18'd0, 18'd0, 18'd1, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
    check_seq("ovf", 3, d8, 6);

    // Reset while zeros remain pending.
    send(1'b0, 5, 18'd7, st);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
    got_q.delete();
    send(1'b0, 0, 18'h123, st);
    drain();
    d8 = '{18'h123, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
    check_seq("post_rst", 1, d8, 0);

    // Random tokens, gaps and backpressure.
    or_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #2;
      end
      send(($urandom_range(7) == 0), int'($urandom_range(7)), 18'($urandom), st);
    end
    or_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rle_decoder.md
# rle_decoder

Expands the run-length token stream of System 2 back into fixed-length blocks of DCT coefficients. It sits on the reconstruction path, between the RLE token source and the inverse-DCT stage, and supplies one coefficient per beat in block order Z0..Z7. Tokens arrive and coefficients leave on independent valid/ready handshakes. A single registered output stage absorbs backpressure.

## Interface
- DATA_W, 18: coefficient width (signed), matching the DCT coefficient outputs
- RUN_W, 3: zero-run field width
- BLK_N, 8: coefficients per block (power of two)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  token present
- in_ready  out  1  decoder accepts token this cycle
- in_value  in  DATA_W  signed coefficient value following the zero run
- in_run  in  RUN_W  number of zeros preceding in_value
- in_eob  in  1  end-of-block token; in_value and in_run ignored
- out_valid  out  1  coefficient present
- out_ready  in  1  downstream accepts coefficient
- out_data  out  DATA_W  signed coefficient
- out_idx  out  log2(BLK_N)  position of out_data within the block
- out_last  out  1  out_idx == BLK_N-1
- err  out  1  sticky run-overflow flag

## Operation
- Token transfer happens on in_valid && in_ready. Output transfer happens on out_valid && out_ready.
- pos counter, 0..BLK_N-1: position of the next beat to generate. It increments on each generated beat and wraps BLK_N-1 -> 0.
- Normal token (in_eob=0, run R, value V):
  - Generates R zero beats, then one beat carrying V: R+1 beats in total.
- EOB token:
  - Generates zeros from pos through BLK_N-1, so pos returns to 0.
  - EOB accepted at pos==0 generates a full block of BLK_N zeros.
- Overflow: a normal token with pos+R > BLK_N-1 (the value cannot fit in the current block).
  - Generates zeros through BLK_N-1 only; V is dropped.
  - pos returns to 0 and err is set.
  - err clears only on reset.
- States:
  - IDLE: no token pending. Transitions to RUN on accepting a normal token with R>0 or an EOB token; to VAL on a normal token with R=0.
  - RUN: emitting zeros, with beats_left counting down. Transitions to VAL when the zeros are done and V remains; to IDLE when an EOB or overflow fill is done.
  - VAL: emitting V. Transitions to IDLE, or directly to RUN/VAL if a new token is accepted in the same cycle.
- in_ready = (output register empty or being emptied this cycle) && (no beats left of the current token after the one being emitted). Back-to-back tokens therefore stream without bubbles.
- out_data, out_idx and out_last are registered. They hold stable while out_valid && !out_ready.
- out_valid never drops without a handshake.
- Arithmetic: pos+R is computed at width log2(BLK_N)+1 for the overflow test. No other arithmetic; V passes through unmodified, sign intact.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, err=0, in_ready=1, pos=0, state IDLE.
- Reset mid-token discards the pending token and any unaccepted output beat.
- Latency: a token accepted in cycle t presents its first beat in cycle t+1.
- Throughput: one beat per cycle while out_ready=1, including across token boundaries.
- A token of R+1 beats holds in_ready low for R cycles, assuming out_ready stays high.
- Simultaneous final-beat handshake and new-token acceptance: the new token's first beat appears the following cycle with no gap.
- err rises in the cycle after the overflowing token is accepted.

## Test plan
- Eight tokens with R=0, V=5, out_ready=1 -> eight beats of 5 with out_idx 0..7 in consecutive cycles; out_last only on idx 7; in_ready never low.
- Token R=2, V=-3, then EOB -> beats 0,0,-3,0,0,0,0,0; out_last on the 8th; next block starts at idx 0.
- EOB at pos 0 -> eight zero beats; err stays 0.
- Token R=3, V=0x1FFFF with out_ready toggling 1,0,0,1,... -> data and idx stable during stalls; exactly the 4 beats 0,0,0,0x1FFFF delivered; no duplicate or loss.
- Overflow: advance pos to 6, then send R=3, V=9 -> zeros at idx 6 and 7; 9 never emitted; err=1 from the next cycle; following token R=0, V=1 emits 1 at idx 0.
- Assert reset while in RUN with 2 beats left -> all outputs at reset values next cycle; err cleared; first token afterwards starts at idx 0.
